// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared definitions for the ALU built-in self-test engine.
//   - state_e      : controller states (IDLE, RUN, DRAIN, DONE)
//   - TAP_MASK     : feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   - DEFAULT_SEED : LFSR start value used when no seed is supplied
//   - parity16 / shift_step : feedback helpers shared by LFSR and MISR
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] TAP_MASK     = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'h00A5;

  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

  // One Fibonacci shift: new LSB is the parity of the tapped bits.
  function automatic logic [15:0] shift_step(input logic [15:0] v, input logic [15:0] taps);
    return {v[14:0], parity16(v & taps)};
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: control and ALU-facing signals of the BIST engine.
//   start/golden        : run request and expected signature
//   busy/done/pass      : run status
//   signature           : current MISR value
//   ui_drv/uio_drv      : stimulus bytes toward the ALU
//   uo_obs/uio_obs      : response bytes from the ALU
// The master side is the controller plus ALU; the slave side is the engine.
interface alu_bist_if;
  logic        start;
  logic [15:0] golden;
  logic [7:0]  ui_drv;
  logic [7:0]  uio_drv;
  logic [7:0]  uo_obs;
  logic [7:0]  uio_obs;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  modport master (
    output start, golden, uo_obs, uio_obs,
    input  ui_drv, uio_drv, busy, done, pass, signature
  );

  modport slave (
    input  start, golden, uo_obs, uio_obs,
    output ui_drv, uio_drv, busy, done, pass, signature
  );
endinterface

// File: rtl/alu_bist_lfsr16.sv
// lfsr16: 16-bit Fibonacci shift register with XOR-in, usable as an LFSR
// (data_in tied to zero) or as a MISR (data_in = compacted response).
//   clk, rst  : clock, synchronous active-high reset (loads INIT)
//   load      : load load_val (wins over enable)
//   load_val  : value to load
//   enable    : advance one step
//   data_in   : word XORed into the shifted value
//   q         : present value
//   q_next    : value that an enabled step would produce
module lfsr16
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] TAPS = TAP_MASK,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        enable,
  input  logic [15:0] data_in,
  output logic [15:0] q,
  output logic [15:0] q_next
);

  logic [15:0] state_r;

  // Next value of the register if it steps this cycle.
  always_comb begin
    q_next = shift_step(state_r, TAPS) ^ data_in;
  end

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT;
    end else if (load) begin
      state_r <= load_val;
    end else if (enable) begin
      state_r <= q_next;
    end else begin
      state_r <= state_r;
    end
  end

  assign q = state_r;

endmodule

// File: rtl/alu_bist.sv
// alu_bist: BIST engine for the tt_um_ALU datapath. Issues PATTERNS LFSR
// vectors, compacts the responses LAT cycles later into a MISR and compares
// the final signature with the supplied golden value.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_bist_if.slave (start, golden, drive/observe bytes, status)
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int          PATTERNS = 256,
  parameter int          LAT      = 1,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic      clk,
  input  logic      rst,
  alu_bist_if.slave bus
);

  localparam logic [15:0] LAST_IDX   = 16'(PATTERNS - 1);
  localparam logic [2:0]  DRAIN_LAST = 3'(LAT - 1);

  state_e      state_r, state_s;
  logic [15:0] cnt_r;
  logic [2:0]  drain_r;
  logic        busy_r, done_r, pass_r;
  logic [15:0] drive_r;
  logic        load_s, finish_s, issue_s, last_vec_s, capture_s;
  logic [15:0] lfsr_q_s, lfsr_nx_s, misr_q_s, misr_nx_s, misr_final_s;
  logic        unused_s;

  assign issue_s    = (state_r == RUN);
  assign last_vec_s = issue_s && (cnt_r == LAST_IDX);

  // Next-state and run control strobes.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (last_vec_s) begin
          if (LAT == 0) begin
            state_s  = DONE;
            finish_s = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s  = DONE;
          finish_s = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Response tags: a vector issued in cycle k is captured at the end of cycle k+LAT.
  if (LAT == 0) begin : g_tag_none
    assign capture_s = issue_s;
  end else if (LAT == 1) begin : g_tag_one
    logic tag_r;
    // Single-stage tag.
    always_ff @(posedge clk) begin
      if (rst || load_s) begin
        tag_r <= 1'b0;
      end else begin
        tag_r <= issue_s;
      end
    end
    assign capture_s = tag_r;
  end else begin : g_tag_multi
    logic [LAT-1:0] tag_r;
    // Tags enter at the top and emerge from bit 0 after LAT cycles.
    always_ff @(posedge clk) begin
      if (rst || load_s) begin
        tag_r <= '0;
      end else begin
        tag_r <= {issue_s, tag_r[LAT-1:1]};
      end
    end
    assign capture_s = tag_r[0];
  end

  // The MISR value that will be held after this edge decides pass.
  assign misr_final_s = capture_s ? misr_nx_s : misr_q_s;

  // Counters, status flags and registered stimulus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 16'd0;
      drain_r <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      drive_r <= 16'h0000;
    end else begin
      if (load_s) begin
        cnt_r <= 16'd0;
      end else if (issue_s) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end

      if (state_r == DRAIN) begin
        drain_r <= drain_r + 3'd1;
      end else begin
        drain_r <= 3'd0;
      end

      busy_r <= (state_s == RUN) || (state_s == DRAIN);

      if (load_s) begin
        done_r <= 1'b0;
        pass_r <= 1'b0;
      end else if (finish_s) begin
        done_r <= 1'b1;
        pass_r <= (misr_final_s == bus.golden);
      end else begin
        done_r <= done_r;
        pass_r <= pass_r;
      end

      // Mirrors the LFSR value that will be current during the next RUN cycle.
      if (state_s == RUN) begin
        drive_r <= load_s ? SEED : lfsr_nx_s;
      end else begin
        drive_r <= 16'h0000;
      end
    end
  end

  lfsr16 #(.TAPS(TAP_MASK), .INIT(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (SEED),
    .enable   (issue_s),
    .data_in  (16'h0000),
    .q        (lfsr_q_s),
    .q_next   (lfsr_nx_s)
  );

  lfsr16 #(.TAPS(TAP_MASK), .INIT(16'h0000)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (16'h0000),
    .enable   (capture_s),
    .data_in  ({bus.uio_obs, bus.uo_obs}),
    .q        (misr_q_s),
    .q_next   (misr_nx_s)
  );

  // The present LFSR value is already carried by drive_r.
  assign unused_s = ^lfsr_q_s;

  assign bus.ui_drv    = drive_r[7:0];
  assign bus.uio_drv   = drive_r[15:8];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.signature = misr_q_s;

endmodule

// File: tb/tb_alu_bist.sv
// tb_alu_bist: scoreboard bench for alu_bist. Three engines share clk/rst:
//   A: PATTERNS=4,   LAT=1, responses tied to zero
//   B: PATTERNS=256, LAT=0, responses looped back from the drive bytes
//   C: PATTERNS=5,   LAT=3, responses looped back through a 3-cycle delay line
`timescale 1ns/1ps
module tb_alu_bist;

  typedef struct {
    int          dut;
    int          cyc;
    logic [15:0] sig;
    logic        pass;
    int          busy_n;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] vec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  exp_t sbq[$];
  vec_t vq[$];
  logic [15:0] sig256, sig5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_bist_if ia();
  alu_bist_if ib();
  alu_bist_if ic();

  alu_bist #(.PATTERNS(4),   .LAT(1), .SEED(16'h00A5)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  alu_bist #(.PATTERNS(256), .LAT(0), .SEED(16'h00A5)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  alu_bist #(.PATTERNS(5),   .LAT(3), .SEED(16'h00A5)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  assign ia.uo_obs  = 8'h00;
  assign ia.uio_obs = 8'h00;
  assign ib.uo_obs  = ib.ui_drv;
  assign ib.uio_obs = ib.uio_drv;

  logic [15:0] dly [3];
  always @(posedge clk) begin
    dly[0] <= {ic.uio_drv, ic.ui_drv};
    dly[1] <= dly[0];
    dly[2] <= dly[1];
  end
  assign ic.uo_obs  = dly[2][7:0];
  assign ic.uio_obs = dly[2][15:8];

  logic        done_v [3];
  logic        busy_v [3];
  logic        pass_v [3];
  logic [15:0] sig_v  [3];
  assign done_v[0] = ia.done;  assign busy_v[0] = ia.busy;
  assign pass_v[0] = ia.pass;  assign sig_v[0]  = ia.signature;
  assign done_v[1] = ib.done;  assign busy_v[1] = ib.busy;
  assign pass_v[1] = ib.pass;  assign sig_v[1]  = ib.signature;
  assign done_v[2] = ic.done;  assign busy_v[2] = ic.busy;
  assign pass_v[2] = ic.pass;  assign sig_v[2]  = ic.signature;

  // Reference Fibonacci step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Signature of n vectors whose responses equal the stimulus words.
  function automatic logic [15:0] model_sig(input int n);
    logic [15:0] l = 16'h00A5;
    logic [15:0] m = 16'h0000;
    for (int k = 0; k < n; k++) begin
      m = step(m) ^ l;
      l = step(l);
    end
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0: ia.start = v;
      1: ib.start = v;
      2: ic.start = v;
      default: ;
    endcase
  endtask

  task automatic set_golden(input int d, input logic [15:0] g);
    case (d)
      0: ia.golden = g;
      1: ib.golden = g;
      2: ic.golden = g;
      default: ;
    endcase
  endtask

  // Compares each done rising edge with the oldest expectation for that engine.
  task automatic monitor();
    logic done_q [3] = '{1'b0, 1'b0, 1'b0};
    int   busy_n [3] = '{0, 0, 0};
    exp_t e;
    vec_t v;
    int   idx;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (done_v[d] && !done_q[d]) begin
          idx = -1;
          foreach (sbq[i]) if (idx < 0 && sbq[i].dut == d) idx = i;
          if (idx < 0) begin
            chk($sformatf("unexpected_done_%0d", d), 1, 0);
          end else begin
            e = sbq[idx];
            sbq.delete(idx);
            chk($sformatf("done_cycle_%0d", d), cyc, e.cyc);
            chk($sformatf("signature_%0d", d), 32'(sig_v[d]), 32'(e.sig));
            chk($sformatf("pass_%0d", d), 32'(pass_v[d]), 32'(e.pass));
            chk($sformatf("busy_cycles_%0d", d), busy_n[d], e.busy_n);
          end
        end
        done_q[d] = done_v[d];
        if (busy_v[d]) busy_n[d]++;
        else busy_n[d] = 0;
        if (busy_n[d] == 400) chk($sformatf("busy_timeout_%0d", d), busy_n[d], 0);
      end
      if (vq.size() > 0 && vq[0].cyc <= cyc) begin
        v = vq.pop_front();
        chk("drive_cycle", cyc, v.cyc);
        chk("drive_vec", 32'({ia.uio_drv, ia.ui_drv}), 32'(v.vec));
      end
    end
  endtask

  // Starts one run and waits (bounded) for done.
  task automatic run(input int d, input logic [15:0] gold, input int n, input int lat,
                     input logic [15:0] esig, input logic epass, input bit vecs, input int pulse);
    exp_t e;
    vec_t v;
    logic [15:0] w = 16'h00A5;
    @(negedge clk);
    set_golden(d, gold);
    set_start(d, 1'b1);
    c0 = cyc;
    e.dut = d; e.cyc = c0 + n + lat + 1; e.sig = esig; e.pass = epass; e.busy_n = n + lat;
    sbq.push_back(e);
    if (vecs) begin
      for (int k = 1; k <= n; k++) begin
        v.cyc = c0 + k; v.vec = w;
        vq.push_back(v);
        w = step(w);
      end
      v.cyc = c0 + n + 1; v.vec = 16'h0000;
      vq.push_back(v);
    end
    @(negedge clk);
    set_start(d, 1'b0);
    for (int i = 0; i < n + lat + 40; i++) begin
      if (pulse > 0 && cyc == c0 + pulse) set_start(d, 1'b1);
      else set_start(d, 1'b0);
      if (done_v[d]) break;
      @(negedge clk);
    end
    set_start(d, 1'b0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    sig256 = model_sig(256);
    sig5   = model_sig(5);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      set_start(d, 1'b0);
      set_golden(d, 16'h0000);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ui_drv",    32'(ia.ui_drv),    0);
    chk("rst_uio_drv",   32'(ia.uio_drv),   0);
    chk("rst_busy",      32'(ia.busy),      0);
    chk("rst_done",      32'(ia.done),      0);
    chk("rst_pass",      32'(ia.pass),      0);
    chk("rst_signature", 32'(ia.signature), 0);

    // Zero responses, golden 0: pass with vectors checked cycle by cycle.
    run(0, 16'h0000, 4, 1, 16'h0000, 1'b1, 1'b1, 0);
    // Golden mismatch, restarted from DONE.
    run(0, 16'h0001, 4, 1, 16'h0000, 1'b0, 1'b0, 0);
    // start pulsed during cycle 3 must be ignored.
    run(0, 16'h0000, 4, 1, 16'h0000, 1'b1, 1'b1, 3);

    // Loopback, twice from DONE, identical signature expected.
    run(1, sig256, 256, 0, sig256, 1'b1, 1'b0, 0);
    run(1, sig256, 256, 0, sig256, 1'b1, 1'b0, 0);

    // Delayed loopback matches the zero-latency reference signature.
    run(2, sig5, 5, 3, sig5, 1'b1, 1'b0, 0);

    // Abort at cycle 10 of a loopback run.
    @(negedge clk);
    ib.golden = sig256;
    ib.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    ib.start = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ui_drv",    32'(ib.ui_drv),    0);
    chk("abort_uio_drv",   32'(ib.uio_drv),   0);
    chk("abort_busy",      32'(ib.busy),      0);
    chk("abort_done",      32'(ib.done),      0);
    chk("abort_pass",      32'(ib.pass),      0);
    chk("abort_signature", 32'(ib.signature), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run(1, sig256, 256, 0, sig256, 1'b1, 1'b0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("vectors_drained", vq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
# alu_bist

Built-in self-test engine for the `tt_um_ALU` datapath. It drives pseudo-random stimulus onto the ALU input bytes from a 16-bit LFSR. It compacts the returned ALU output bytes into a 16-bit MISR signature and compares the result against a supplied golden value. It sits on-chip between the pin mux and the ALU, and does on silicon what the cocotb bench does in simulation.

## Interface
Parameters:
- `PATTERNS`, default 256: number of stimulus vectors per run, range 1–65535.
- `LAT`, default 1: ALU input-to-output latency in cycles, range 0–7.
- `SEED`, default 16'h00A5: LFSR start value. Must be nonzero.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a run. Sampled in IDLE or DONE only.
- `golden`  in  16: expected signature.
- `ui_drv`  out  8: stimulus to ALU `ui_in`.
- `uio_drv`  out  8: stimulus to ALU `uio_in`.
- `uo_obs`  in  8: ALU `uo_out`.
- `uio_obs`  in  8: ALU `uio_out`.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete. Held until the next start or reset.
- `pass`  out  1: signature equals golden. Valid while `done`=1.
- `signature`  out  16: current MISR value.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after `PATTERNS` vectors have been issued. When `LAT`=0, RUN goes straight to DONE.
  - DRAIN → DONE after `LAT` cycles.
  - DONE → RUN on `start`.
- LFSR is Fibonacci with polynomial x^16+x^14+x^13+x^11+1.
  - Next value = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - It advances once per issued vector.
- Stimulus during RUN: `ui_drv`=l[7:0], `uio_drv`=l[15:8]. Outside RUN both are 0.
- Capture pipeline: a `LAT`-deep valid shift register tags each issued vector. The MISR updates only on cycles where the tag emerges.
- MISR update: m_next = {m[14:0], m[15]^m[13]^m[12]^m[10]} ^ {uio_obs, uo_obs}.
- On `start`: LFSR is loaded with `SEED`, MISR is cleared to 0, the pattern counter is cleared, and `done`/`pass` are cleared.
- `pass` is registered on the DRAIN→DONE (or RUN→DONE) transition as (m_next or final m) == `golden`.
- `start` while `busy` is ignored.
- Pattern counter is 16 bits and does not wrap. A run ends exactly when the count reaches `PATTERNS`.

## Timing
- Reset values: `ui_drv`=0, `uio_drv`=0, `busy`=0, `done`=0, `pass`=0, `signature`=0. Internally LFSR=`SEED`, MISR=0, state=IDLE.
- `rst` mid-run aborts immediately to the reset values. No partial `done` is produced.
- `start` high at cycle 0 (IDLE): `busy`=1 from cycle 1.
- Vector k (k=1..`PATTERNS`) is on the drive outputs during cycle k. The first vector is `SEED`.
- Vector k's response is sampled at the clock edge ending cycle k+`LAT`.
- `busy` falls and `done` rises at cycle `PATTERNS`+`LAT`+1. `pass` is valid the same cycle.
- `signature` updates combinationally-free (registered). It reflects all captures up to the previous edge.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package `alu_bist_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the LFSR/MISR tap mask constant 16'hB400;
  - the default seed.
- One sub-module, `lfsr16`, with parameterised tap mask, `load`, `enable`, and `data_in` (XOR-in). Instantiate it twice: once with `data_in`=0 as the LFSR, once as the MISR.

## Test plan
- Reset, then `start` with `SEED`=16'h00A5 and `uo_obs`/`uio_obs` tied to 0. Drive outputs must be 16'h00A5, 16'h014A, 16'h0294, 16'h0528 on cycles 1–4.
- `PATTERNS`=4, `LAT`=1, observed bytes tied to 0, `golden`=0. `done` rises at cycle 6 with `signature`=16'h0000 and `pass`=1. `busy` is high on cycles 1–5.
- Same run with `golden`=16'h0001: `done`=1, `pass`=0.
- Loopback (`uo_obs`=`ui_drv`, `uio_obs`=`uio_drv`, `LAT`=0), `PATTERNS`=256. `signature` must match the reference model's MISR. A second `start` from DONE must reproduce the identical signature.
- `start` pulsed at cycle 3 of a run: no restart, and `done` timing is unchanged.
- `rst` asserted at cycle 10 of a 256-pattern run: all outputs are at reset values on cycle 11. A subsequent `start` produces the same signature as a clean run.
